// File: rtl/vga_rom_arbiter.sv
// Shares the single-port glyph/image ROM between the VGA display path (absolute priority)
// and a background req/gnt port, with per-port read-valid strobes and a starvation flag.
module vga_rom_arbiter #(
    parameter int unsigned ROM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 800
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic        disp_req,
    input  logic [5:0]  disp_addr,
    output logic        disp_valid,
    output logic [63:0] disp_data,
    input  logic        bg_req,
    input  logic [5:0]  bg_addr,
    output logic        bg_gnt,
    output logic        bg_valid,
    output logic [63:0] bg_data,
    output logic        bg_starved,
    output logic [5:0]  rom_addr,
    input  logic [63:0] rom_data
);

    localparam logic [11:0] LIMIT = 12'(STARVE_LIMIT);

    logic               w_issue;
    logic [ROM_LAT-1:0] w_tag_v_d;
    logic [ROM_LAT-1:0] w_tag_bg_d;
    logic               w_tail_v;
    logic               w_tail_bg;
    logic [11:0]        w_cnt_d;

    logic [5:0]         r_last_addr;
    logic [ROM_LAT-1:0] r_tag_v;
    logic [ROM_LAT-1:0] r_tag_bg;
    logic               r_bg_valid;
    logic [63:0]        r_bg_data;
    logic [11:0]        r_cnt;
    logic               r_starved;

    // Idle cycles replay the last issued address so the ROM address bus stays quiet.
    always_comb begin
        w_issue = disp_req | bg_req;
        bg_gnt  = bg_req & ~disp_req;
        if (disp_req) begin
            rom_addr = disp_addr;
        end else if (bg_req) begin
            rom_addr = bg_addr;
        end else begin
            rom_addr = r_last_addr;
        end
    end

    if (ROM_LAT == 1) begin : g_tag_lat1
        always_comb begin
            w_tag_v_d  = w_issue;
            w_tag_bg_d = bg_gnt;
        end
    end else begin : g_tag_latn
        always_comb begin
            w_tag_v_d  = {r_tag_v[ROM_LAT-2:0], w_issue};
            w_tag_bg_d = {r_tag_bg[ROM_LAT-2:0], bg_gnt};
        end
    end

    always_comb begin
        w_tail_v   = r_tag_v[ROM_LAT-1];
        w_tail_bg  = r_tag_bg[ROM_LAT-1];
        disp_valid = w_tail_v & ~w_tail_bg;
        disp_data  = rom_data;
        bg_valid   = r_bg_valid;
        bg_data    = r_bg_data;
        bg_starved = r_starved;
    end

    always_comb begin
        w_cnt_d = r_cnt;
        if (!bg_req || bg_gnt) begin
            w_cnt_d = 12'd0;
        end else if (r_cnt < LIMIT) begin
            w_cnt_d = r_cnt + 12'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr <= 6'd0;
            r_tag_v     <= '0;
            r_tag_bg    <= '0;
            r_bg_valid  <= 1'b0;
            r_bg_data   <= 64'd0;
            r_cnt       <= 12'd0;
            r_starved   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_last_addr <= rom_addr;
            end
            r_tag_v    <= w_tag_v_d;
            r_tag_bg   <= w_tag_bg_d;
            r_bg_valid <= w_tail_v & w_tail_bg;
            if (w_tail_v && w_tail_bg) begin
                r_bg_data <= rom_data;
            end
            r_cnt     <= w_cnt_d;
            // Registered from the next count so the flag drops right after the grant edge.
            r_starved <= (w_cnt_d >= LIMIT);
        end
    end

endmodule

// File: tb/tb_vga_rom_arbiter.sv
// Directed bench for vga_rom_arbiter: ROM model plus a per-port scoreboard of expected
// read-return cycle and data.
module tb_vga_rom_arbiter;

    localparam int unsigned ROM_LAT      = 1;
    localparam int unsigned STARVE_LIMIT = 10;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } exp_t;

    logic        vga_clk;
    logic        rst_n;
    logic        disp_req;
    logic [5:0]  disp_addr;
    logic        disp_valid;
    logic [63:0] disp_data;
    logic        bg_req;
    logic [5:0]  bg_addr;
    logic        bg_gnt;
    logic        bg_valid;
    logic [63:0] bg_data;
    logic        bg_starved;
    logic [5:0]  rom_addr;
    logic [63:0] rom_data;
    logic [63:0] rom_q1;
    logic [63:0] rom_q2;

    int   cyc;
    int   checks;
    int   errors;
    exp_t dq[$];
    exp_t bq[$];

    vga_rom_arbiter #(
        .ROM_LAT      (ROM_LAT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .vga_clk    (vga_clk),
        .rst_n      (rst_n),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .bg_req     (bg_req),
        .bg_addr    (bg_addr),
        .bg_gnt     (bg_gnt),
        .bg_valid   (bg_valid),
        .bg_data    (bg_data),
        .bg_starved (bg_starved),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
    );

    function automatic logic [63:0] rom_word(input logic [5:0] a);
        return {16{a[3:0]}};
    endfunction

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) begin
        rom_q1 <= rom_word(rom_addr);
        rom_q2 <= rom_q1;
    end
    assign rom_data = (ROM_LAT == 2) ? rom_q2 : rom_q1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_disp(input logic [5:0] a);
        exp_t e;
        e.cyc  = cyc + ROM_LAT;
        e.data = rom_word(a);
        dq.push_back(e);
    endtask

    task automatic push_bg(input logic [5:0] a);
        exp_t e;
        e.cyc  = cyc + ROM_LAT + 1;
        e.data = rom_word(a);
        bq.push_back(e);
    endtask

    // Pops expected returns as strobes appear; also flags strobes that arrive late or never.
    task automatic monitor();
        exp_t e;
        if (disp_valid === 1'b1) begin
            if (dq.size() == 0) begin
                check("disp_extra", {63'd0, disp_valid}, 64'd0);
            end else begin
                e = dq.pop_front();
                check("disp_cyc", 64'(cyc), 64'(e.cyc));
                check("disp_data", disp_data, e.data);
            end
        end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
            e = dq.pop_front();
            check("disp_missing", {63'd0, disp_valid}, 64'd1);
        end
        if (bg_valid === 1'b1) begin
            if (bq.size() == 0) begin
                check("bg_extra", {63'd0, bg_valid}, 64'd0);
            end else begin
                e = bq.pop_front();
                check("bg_cyc", 64'(cyc), 64'(e.cyc));
                check("bg_data", bg_data, e.data);
            end
        end else if (bq.size() != 0 && bq[0].cyc <= cyc) begin
            e = bq.pop_front();
            check("bg_missing", {63'd0, bg_valid}, 64'd1);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        cyc++;
        @(negedge vga_clk);
        monitor();
    endtask

    initial begin
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        disp_req  = 1'b0;
        disp_addr = 6'd0;
        bg_req    = 1'b0;
        bg_addr   = 6'd0;
        #1;
        check("rst_disp_valid", {63'd0, disp_valid}, 64'd0);
        check("rst_bg_valid", {63'd0, bg_valid}, 64'd0);
        check("rst_bg_data", bg_data, 64'd0);
        check("rst_starved", {63'd0, bg_starved}, 64'd0);
        check("rst_rom_addr", {58'd0, rom_addr}, 64'd0);
        check("rst_bg_gnt", {63'd0, bg_gnt}, 64'd0);
        @(negedge vga_clk);
        rst_n = 1'b1;
        tick();

        // Continuous display stream over every address.
        for (int k = 0; k < 64; k++) begin
            disp_req  = 1'b1;
            disp_addr = 6'(k);
            #1;
            check("stream_rom_addr", {58'd0, rom_addr}, 64'(k));
            check("stream_bg_gnt", {63'd0, bg_gnt}, 64'd0);
            push_disp(6'(k));
            tick();
        end
        disp_req = 1'b0;
        #1;
        check("stream_idle_addr", {58'd0, rom_addr}, 64'd63);
        tick();
        tick();

        // Background alone.
        bg_req  = 1'b1;
        bg_addr = 6'h2A;
        #1;
        check("bg_gnt_alone", {63'd0, bg_gnt}, 64'd1);
        check("bg_rom_addr", {58'd0, rom_addr}, 64'd42);
        push_bg(6'h2A);
        tick();
        bg_req  = 1'b0;
        bg_addr = 6'h11;
        #1;
        check("bg_gnt_drop", {63'd0, bg_gnt}, 64'd0);
        check("bg_idle_addr", {58'd0, rom_addr}, 64'd42);
        for (int k = 0; k < 4; k++) tick();
        check("bg_data_held", bg_data, rom_word(6'h2A));
        check("bg_valid_pulse", {63'd0, bg_valid}, 64'd0);

        // Contention: display pulses 1,1,1,0 while background waits.
        bg_req  = 1'b1;
        bg_addr = 6'h15;
        for (int k = 0; k < 4; k++) begin
            disp_req  = (k < 3);
            disp_addr = 6'(k + 5);
            #1;
            check("cont_gnt", {63'd0, bg_gnt}, (k == 3) ? 64'd1 : 64'd0);
            if (k < 3) push_disp(6'(k + 5));
            else push_bg(6'h15);
            tick();
        end
        bg_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("cont_bg_data", bg_data, rom_word(6'h15));

        // Starvation, limit 10, both ports held for 15 cycles.
        bg_req    = 1'b1;
        bg_addr   = 6'h3F;
        disp_req  = 1'b1;
        disp_addr = 6'd0;
        for (int k = 1; k <= 15; k++) begin
            #1;
            check("starve_gnt", {63'd0, bg_gnt}, 64'd0);
            push_disp(6'd0);
            tick();
            check("starve_flag", {63'd0, bg_starved}, (k >= 10) ? 64'd1 : 64'd0);
        end
        disp_req = 1'b0;
        #1;
        check("starve_gnt_final", {63'd0, bg_gnt}, 64'd1);
        check("starve_flag_gnt", {63'd0, bg_starved}, 64'd1);
        push_bg(6'h3F);
        tick();
        check("starve_clear", {63'd0, bg_starved}, 64'd0);
        bg_req = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("starve_bg_data", bg_data, rom_word(6'h3F));

        // Reset one cycle after a background grant; the in-flight read must vanish.
        bg_req  = 1'b1;
        bg_addr = 6'h2B;
        #1;
        check("rmid_gnt", {63'd0, bg_gnt}, 64'd1);
        tick();
        bg_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rmid_disp_valid", {63'd0, disp_valid}, 64'd0);
        check("rmid_bg_valid", {63'd0, bg_valid}, 64'd0);
        check("rmid_bg_data", bg_data, 64'd0);
        check("rmid_starved", {63'd0, bg_starved}, 64'd0);
        check("rmid_rom_addr", {58'd0, rom_addr}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("rmid_post_addr", {58'd0, rom_addr}, 64'd0);
        check("rmid_post_data", bg_data, 64'd0);

        check("disp_queue_empty", 64'(dq.size()), 64'd0);
        check("bg_queue_empty", 64'(bq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
